// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: datapath slice width and
// the state encoding of the sequencing FSM.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_adder_bit_adder.sv
// bit_adder: combinational 4-bit ripple-carry adder.
// Ports:
//   a_i, b_i  - nibble operands
//   c0_i      - carry into bit 0
//   s_o       - nibble sum
//   c4_o      - carry out of bit 3
module bit_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c0_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                c4_o
);

    logic [NIBBLE_W:0] carry;

    // Full-adder chain, one bit at a time.
    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = c0_i;
        for (int i = 0; i < int'(NIBBLE_W); i++) begin
            s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c4_o = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder built from one 4-bit adder stage,
// processing one nibble per cycle (LSB nibble first) with the inter-nibble
// carry held in a register.
// Ports:
//   CLK, RST             - clock, asynchronous active-high reset
//   A, B, CIN            - operands, sampled when IN_VALID && IN_READY
//   IN_VALID, IN_READY   - input handshake
//   S, COUT              - {COUT,S} = A + B + CIN, valid with OUT_VALID
//   OUT_VALID, OUT_READY - output handshake
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
        $fatal(1, "nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
    end

    logic [1:0]          state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NIBBLE_W-1:0] add_s;
    logic                add_c4;

    // The single shared nibble adder always sees the low nibbles.
    bit_adder u_bit_adder (
        .a_i  (a_q[NIBBLE_W-1:0]),
        .b_i  (b_q[NIBBLE_W-1:0]),
        .c0_i (carry_q),
        .s_o  (add_s),
        .c4_o (add_c4)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CIN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New nibble enters at the top; after NIBBLES shifts the
                // first nibble has reached bit 0.
                sum_d   = (sum_q >> NIBBLE_W) | (WIDTH'(add_s) << (WIDTH - NIBBLE_W));
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                carry_d = add_c4;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign S         = sum_q;
    assign COUT      = carry_q;
    assign OUT_VALID = (state_q == DONE);
    assign IN_READY  = (state_q == IDLE);

endmodule
